// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   RES_MEM            : result-source encoding that marks a load
//   FWD_*              : encodings of the execute-stage forwarding selects
//   state_t            : hazard FSM state (run / waiting on data memory)
package hazard_pkg;

    localparam logic [2:0] RES_MEM = 3'b001;

    localparam logic [1:0] FWD_RF = 2'd0;  // register file
    localparam logic [1:0] FWD_M  = 2'd1;  // ALU result in M
    localparam logic [1:0] FWD_W  = 2'd2;  // writeback value
    localparam logic [1:0] FWD_W2 = 2'd3;  // writeback delayed by one cycle

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MEMWAIT = 1'b1
    } state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding select for one execute-stage source register.
//   rs                       : source register in E
//   rd_m/reg_write_m/res_src_m : producer in M (loads never forward from M)
//   rd_w/reg_write_w         : producer in W
//   wb_rd/wb_vld             : writeback retired one cycle earlier
//   sel                      : FWD_RF / FWD_M / FWD_W / FWD_W2
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [2:0] res_src_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    input  logic [4:0] wb_rd,
    input  logic       wb_vld,
    output logic [1:0] sel
);

    // x0 is hard-wired to zero, so a match on it is never a real dependency.
    always_comb begin
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (reg_write_m && (rd_m == rs) && (res_src_m != RES_MEM))
                sel = FWD_M;
            else if (reg_write_w && (rd_w == rs))
                sel = FWD_W;
            else if (wb_vld && (wb_rd == rs))
                sel = FWD_W2;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core.
//   Inputs : decode/execute source registers, E/M/W destinations and write
//            enables, result sources, data-memory request/ready, PCSrcE.
//   Outputs: forwarding selects, stall and flush controls for the pipeline
//            registers, stall/flush performance counters, fsm_state (debug).
// Handshake: a data-memory access in M is outstanding while
//   MemReqM=1 and mem_ready=0; the whole pipe freezes for exactly those
//   cycles and the access completes in the cycle mem_ready=1.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             UseRs1D,
    input  logic             UseRs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [2:0]       ResultSrcE,
    input  logic [2:0]       ResultSrcM,
    input  logic             MemReqM,
    input  logic             mem_ready,
    input  logic             PCSrcE,
    output logic [1:0]       Hazardmux_sel1,
    output logic [1:0]       Hazardmux_sel2,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output state_t           fsm_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic       freeze;
    logic       load_use;
    logic       branch_flush;
    logic [4:0] wb_rd_q;
    logic       wb_vld_q;
    logic [1:0] sel1_raw;
    logic [1:0] sel2_raw;

    // Freeze is combinational so the very first wait cycle already holds
    // the pipe; the FSM only records that a wait is in progress.
    assign freeze = MemReqM & ~mem_ready;

    assign load_use = RegWriteE & (ResultSrcE == RES_MEM) & (RD_E != 5'd0) &
                      ((UseRs1D & (RD_E == Rs1D)) | (UseRs2D & (RD_E == Rs2D)));

    // A taken branch during a freeze waits: E is held, so PCSrcE is still
    // asserted on the first unfrozen cycle.
    assign branch_flush = ~freeze & PCSrcE;

    fwd_select u_fwd1 (
        .rs          (Rs1E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .res_src_m   (ResultSrcM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .wb_rd       (wb_rd_q),
        .wb_vld      (wb_vld_q),
        .sel         (sel1_raw)
    );

    fwd_select u_fwd2 (
        .rs          (Rs2E),
        .rd_m        (RD_M),
        .reg_write_m (RegWriteM),
        .res_src_m   (ResultSrcM),
        .rd_w        (RD_W),
        .reg_write_w (RegWriteW),
        .wb_rd       (wb_rd_q),
        .wb_vld      (wb_vld_q),
        .sel         (sel2_raw)
    );

    // Priority: freeze > branch flush > load-use. A branch squashes the
    // decode instruction, so its load-use stall would be pointless.
    // Everything is forced low while reset is held.
    always_comb begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        Hazardmux_sel1 = FWD_RF;
        Hazardmux_sel2 = FWD_RF;
        if (rst) begin
            Hazardmux_sel1 = sel1_raw;
            Hazardmux_sel2 = sel2_raw;
            if (freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_state <= S_RUN;
            wb_rd_q   <= 5'd0;
            wb_vld_q  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (fsm_state)
                S_RUN:     if (freeze)    fsm_state <= S_MEMWAIT;
                S_MEMWAIT: if (mem_ready) fsm_state <= S_RUN;
                default:                  fsm_state <= S_RUN;
            endcase
            // The delayed writeback holds with the rest of the pipe.
            if (!freeze) begin
                wb_rd_q  <= RD_W;
                wb_vld_q <= RegWriteW;
            end
            if (StallF)       stall_cnt <= stall_cnt + CNT_ONE;
            if (branch_flush) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios followed by random
// traffic, each cycle's expected outputs queued by a reference model and
// compared by an independent monitor on the falling edge.
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int CNT_W = 32;
    localparam int EW    = 1 + 2 + 2 + 4 + 3 + 2 * CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
    logic       UseRs1D, UseRs2D, RegWriteE, RegWriteM, RegWriteW;
    logic [2:0] ResultSrcE, ResultSrcM;
    logic       MemReqM, mem_ready, PCSrcE;
    logic [1:0] Hazardmux_sel1, Hazardmux_sel2;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    state_t     fsm_state;

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
        .MemReqM(MemReqM), .mem_ready(mem_ready), .PCSrcE(PCSrcE),
        .Hazardmux_sel1(Hazardmux_sel1), .Hazardmux_sel2(Hazardmux_sel2),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fsm_state(fsm_state)
    );

    // ---------------- reference model state ----------------
    logic [EW-1:0]    exp_q[$];
    logic             m_wait;      // a memory wait is in progress
    logic [4:0]       m_wb_rd;     // register written back last unfrozen cycle
    logic             m_wb_vld;
    logic [CNT_W-1:0] m_stalls;
    logic [CNT_W-1:0] m_flushes;
    int               n_tests = 0;
    int               n_fail  = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return 2'd0;
        if (RegWriteM && RD_M == rs && ResultSrcM != RES_MEM) return 2'd1;
        if (RegWriteW && RD_W == rs) return 2'd2;
        if (m_wb_vld && m_wb_rd == rs) return 2'd3;
        return 2'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic clear_inputs();
        rst = 1'b1;
        Rs1D = 0; Rs2D = 0; UseRs1D = 0; UseRs2D = 0;
        Rs1E = 0; Rs2E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        ResultSrcE = 0; ResultSrcM = 0;
        MemReqM = 0; mem_ready = 1; PCSrcE = 0;
    endtask

    // Inputs for this cycle are already applied; predict, queue, advance.
    task automatic step();
        logic       freeze, lu;
        logic [1:0] s1, s2;
        logic [3:0] st;   // F D E M
        logic [2:0] fl;   // D E W
        freeze = MemReqM && !mem_ready;
        lu = RegWriteE && ResultSrcE == RES_MEM && RD_E != 0 &&
             ((UseRs1D && RD_E == Rs1D) || (UseRs2D && RD_E == Rs2D));
        s1 = 0; s2 = 0; st = 0; fl = 0;
        if (rst) begin
            s1 = ref_fwd(Rs1E);
            s2 = ref_fwd(Rs2E);
            if (freeze)      begin st = 4'b1111; fl = 3'b001; end
            else if (PCSrcE) begin fl = 3'b110; end
            else if (lu)     begin st = 4'b1100; fl = 3'b010; end
        end
        exp_q.push_back({m_wait, s1, s2, st, fl, m_stalls, m_flushes});
        if (!rst) begin
            m_wait = 0; m_wb_rd = 0; m_wb_vld = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (st[3]) m_stalls = m_stalls + 1;
            if (!freeze && PCSrcE) m_flushes = m_flushes + 1;
            if (!freeze) begin m_wb_rd = RD_W; m_wb_vld = RegWriteW; end
            m_wait = m_wait ? !mem_ready : freeze;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",     64'(fsm_state == S_MEMWAIT), 64'(e[EW-1]));
            check("sel1",      64'(Hazardmux_sel1), 64'(e[EW-2 -: 2]));
            check("sel2",      64'(Hazardmux_sel2), 64'(e[EW-4 -: 2]));
            check("stalls",    64'({StallF, StallD, StallE, StallM}), 64'(e[EW-6 -: 4]));
            check("flushes",   64'({FlushD, FlushE, FlushW}), 64'(e[EW-10 -: 3]));
            check("stall_cnt", 64'(stall_cnt), 64'(e[2*CNT_W-1 -: CNT_W]));
            check("flush_cnt", 64'(flush_cnt), 64'(e[CNT_W-1:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m_wait = 0; m_wb_rd = 0; m_wb_vld = 0; m_stalls = 0; m_flushes = 0;
        clear_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
        step();                                   // reset held: all zero
        clear_inputs(); step();

        // add x5 in M forwards to Rs1E; RD_M=0 never forwards
        RegWriteM = 1; RD_M = 5; Rs1E = 5; step();
        RD_M = 0; Rs1E = 0; step();
        clear_inputs();

        // lw x6 in E, decode reads x6: one stall cycle, then W forwards
        RegWriteE = 1; ResultSrcE = RES_MEM; RD_E = 6; UseRs2D = 1; Rs2D = 6; step();
        clear_inputs(); RegWriteW = 1; RD_W = 6; Rs2E = 6; step();

        // x7 from W, next cycle select 3
        clear_inputs(); RegWriteW = 1; RD_W = 7; step();
        clear_inputs(); Rs1E = 7; step();
        // same across a two-cycle freeze
        clear_inputs(); RegWriteW = 1; RD_W = 7; step();
        clear_inputs(); MemReqM = 1; mem_ready = 0; step(); step();
        mem_ready = 1; Rs1E = 7; step();

        // branch together with a load-use condition: flush wins
        clear_inputs(); PCSrcE = 1;
        RegWriteE = 1; ResultSrcE = RES_MEM; RD_E = 9; UseRs1D = 1; Rs1D = 9; step();

        // three-cycle freeze with a pending branch, flush on the fourth
        clear_inputs(); PCSrcE = 1; MemReqM = 1; mem_ready = 0;
        step(); step(); step();
        mem_ready = 1; step();

        // reset in the middle of a memory wait
        clear_inputs(); MemReqM = 1; mem_ready = 0; step(); step();
        rst = 0; step();
        rst = 1; step();

        // random traffic over a small register set to provoke matches
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 60) != 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            UseRs1D    = 1'($urandom_range(0, 1));
            UseRs2D    = 1'($urandom_range(0, 1));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RD_E       = 5'($urandom_range(0, 3));
            RD_M       = 5'($urandom_range(0, 3));
            RD_W       = 5'($urandom_range(0, 3));
            RegWriteE  = 1'($urandom_range(0, 1));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = $urandom_range(0, 1) ? RES_MEM : 3'($urandom_range(0, 7));
            ResultSrcM = $urandom_range(0, 1) ? RES_MEM : 3'($urandom_range(0, 7));
            MemReqM    = ($urandom_range(0, 2) == 0);
            mem_ready  = ($urandom_range(0, 2) != 0);
            PCSrcE     = ($urandom_range(0, 5) == 0);
            step();
        end

        clear_inputs();
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
